// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, ROM address window, fetch buffer sizing and NOP encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          ROM_ADDR_LSB = 2;
  localparam int          ROM_ADDR_MSB = 7;
  localparam int          IF_BUF_DEPTH = 2;
  localparam int          IF_CNT_W     = $clog2(IF_BUF_DEPTH + 1);
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

  localparam int IF_ENTRY_W = $bits(if_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:ROM_ADDR_LSB], {ROM_ADDR_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/if_buf.sv
// Two-entry FIFO for fetched {pc, inst} pairs. Entry e0 is always the head, so the
// head outputs keep their last value after the buffer empties.
module if_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W = IF_ENTRY_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [DATA_W-1:0]   din,
  output logic [IF_CNT_W-1:0] count,
  output logic [DATA_W-1:0]   head
);

  localparam logic [IF_CNT_W-1:0] CNT_ONE = IF_CNT_W'(1);
  localparam logic [IF_CNT_W-1:0] CNT_TWO = IF_CNT_W'(2);

  logic [DATA_W-1:0] e0;
  logic [DATA_W-1:0] e1;
  logic              wr_e1;

  assign head = e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head register is reset so the decode-facing outputs start at {0, NOP}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0 <= '0;
    end else if (!flush) begin
      if (pop) begin
        if (count == CNT_TWO) e0 <= e1;
        else if (push)        e0 <= din;
      end else if (push && count == '0) begin
        e0 <= din;
      end
    end
  end

  assign wr_e1 = !flush && push &&
                 ((count == CNT_TWO && pop) || (count == CNT_ONE && !pop));

  always_ff @(posedge clk) begin
    if (wr_e1) e1 <= din;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM address and queues {pc, inst} for decode.
// Optional IF_BOUND_CHECK_EN halts fetch and raises fault when pc leaves the 256-byte ROM window.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_a,
  input  logic [31:0] rom_inst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        fault
);

  logic [31:0]         pc;
  logic                halted;
  logic                fetch_try;
  logic                has_room;
  logic                push;
  logic                pop;
  logic [IF_CNT_W-1:0] count;
  if_entry_t           head;
  if_entry_t           din;

  assign rom_a     = pc;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  // A redirect discards any handshake in the same cycle.
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign fetch_try = !redirect_valid && !stall && !halted;
  assign has_room  = (count < IF_CNT_W'(IF_BUF_DEPTH)) || pop;

`ifdef IF_BOUND_CHECK_EN
  logic oob;

  assign oob  = |pc[31:ROM_ADDR_MSB+1];
  assign push = fetch_try && has_room && !oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
      fault  <= 1'b0;
    end else if (redirect_valid) begin
      halted <= 1'b0;
      fault  <= 1'b0;
    end else if (fetch_try && oob) begin
      halted <= 1'b1;
      fault  <= 1'b1;
    end
  end
`else
  assign push   = fetch_try && has_room;
  assign halted = 1'b0;
  assign fault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  assign din.pc   = pc;
  assign din.inst = rom_inst;

  if_buf #(
    .DATA_W (IF_ENTRY_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: table of per-cycle vectors plus hand sequences for
// address wrap / bound check and asynchronous reset mid-stream.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_a;
  logic [31:0] rom_inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        fault;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        st;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ea;
    logic        ef;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1300_0000 | {26'd0, a[7:2]};
  endfunction

  assign rom_inst = rom_word(rom_a);

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_a          (rom_a),
    .rom_inst       (rom_inst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic st,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] ea, input logic ef);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.st = st; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ea = ea; v.ef = ef;
    return v;
  endfunction

  // Apply inputs just after a falling edge, check state outputs, then cross one rising edge.
  task automatic step(input vec_t v, input string tag);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    stall          = v.st;
    out_ready      = v.rdy;
    #1;
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.ev});
    chk({tag, " rom_a"}, rom_a, v.ea);
    chk({tag, " fault"}, {31'd0, fault}, {31'd0, v.ef});
    if (v.ev) begin
      chk({tag, " out_pc"}, out_pc, v.epc);
      chk({tag, " out_inst"}, out_inst, rom_word(v.epc));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //            rv rpc           st rdy ev epc           rom_a         f
    tbl[0]  = mk(0, 32'h0,        0, 1,  0, 32'h0,        32'h00,       0);
    tbl[1]  = mk(0, 32'h0,        0, 1,  1, 32'h0,        32'h04,       0);
    tbl[2]  = mk(0, 32'h0,        0, 1,  1, 32'h4,        32'h08,       0);
    tbl[3]  = mk(0, 32'h0,        0, 0,  1, 32'h8,        32'h0C,       0);
    tbl[4]  = mk(0, 32'h0,        0, 0,  1, 32'h8,        32'h10,       0);
    tbl[5]  = mk(0, 32'h0,        0, 0,  1, 32'h8,        32'h10,       0);
    tbl[6]  = mk(0, 32'h0,        0, 0,  1, 32'h8,        32'h10,       0);
    tbl[7]  = mk(0, 32'h0,        0, 0,  1, 32'h8,        32'h10,       0);
    tbl[8]  = mk(0, 32'h0,        0, 1,  1, 32'h8,        32'h10,       0);
    tbl[9]  = mk(0, 32'h0,        0, 1,  1, 32'hC,        32'h14,       0);
    tbl[10] = mk(1, 32'h23,       0, 0,  1, 32'h10,       32'h18,       0);
    tbl[11] = mk(0, 32'h0,        0, 1,  0, 32'h0,        32'h20,       0);
    tbl[12] = mk(0, 32'h0,        0, 0,  1, 32'h20,       32'h24,       0);
    tbl[13] = mk(0, 32'h0,        1, 1,  1, 32'h20,       32'h28,       0);
    tbl[14] = mk(0, 32'h0,        1, 1,  1, 32'h24,       32'h28,       0);
    tbl[15] = mk(0, 32'h0,        1, 1,  0, 32'h0,        32'h28,       0);
    tbl[16] = mk(0, 32'h0,        0, 1,  0, 32'h0,        32'h28,       0);
    tbl[17] = mk(1, 32'hFFFF_FFFC, 0, 1, 1, 32'h28,       32'h2C,       0);

    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset rom_a", rom_a, 32'h0);
    chk("reset out_pc", out_pc, 32'h0);
    chk("reset out_inst", out_inst, 32'h0);
    chk("reset fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

`ifndef IF_BOUND_CHECK_EN
    step(mk(0, 32'h0, 0, 1, 0, 32'h0,         32'hFFFF_FFFC, 0), "wrap0");
    step(mk(0, 32'h0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0,         0), "wrap1");
    step(mk(0, 32'h0, 0, 1, 1, 32'h0,         32'h4,         0), "wrap2");
`else
    step(mk(0, 32'h0,   0, 1, 0, 32'h0, 32'hFFFF_FFFC, 0), "bnd0");
    step(mk(1, 32'h100, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 1), "bnd1");
    step(mk(0, 32'h0,   0, 1, 0, 32'h0, 32'h100,       0), "bnd2");
    step(mk(0, 32'h0,   0, 1, 0, 32'h0, 32'h100,       1), "bnd3");
    step(mk(1, 32'h0,   0, 1, 0, 32'h0, 32'h100,       1), "bnd4");
    step(mk(0, 32'h0,   0, 1, 0, 32'h0, 32'h0,         0), "bnd5");
    step(mk(0, 32'h0,   0, 1, 1, 32'h0, 32'h4,         0), "bnd6");
`endif

    // Fill the buffer, then pull reset between edges: state must clear without a clock.
    step(mk(0, 32'h0, 0, 0, 1, 32'h4, 32'h8, 0), "prerst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst rom_a", rom_a, 32'h0);
    chk("async rst out_pc", out_pc, 32'h0);
    chk("async rst out_inst", out_inst, 32'h0);
    chk("async rst fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 0), "post0");
    step(mk(0, 32'h0, 0, 1, 1, 32'h0, 32'h4, 0), "post1");
    step(mk(0, 32'h0, 0, 1, 1, 32'h4, 32'h8, 0), "post2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
